// File: rtl/ball_engine.sv
// Pong ball engine: per-frame ball motion, wall/paddle reflection, miss detection,
// scoring and the serve/play/game-over sequence. All outputs are registered.
module ball_engine #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned BALL_HALF    = 5,
  parameter int unsigned PADDLE_HALF  = 20,
  parameter int unsigned R_PADDLE_X   = 540,
  parameter int unsigned L_PADDLE_X   = 100,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_count,
  input  logic [9:0] y_count,
  input  logic [9:0] right_paddle_pos,
  input  logic [9:0] left_paddle_pos,
  output logic [9:0] ball_x_pos,
  output logic [9:0] ball_y_pos,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       serving,
  output logic       game_over,
  output logic       hit
);

  typedef enum logic [1:0] {StServe, StPlay, StGameOver} state_e;

  localparam logic [10:0] Half      = 11'(BALL_HALF);
  localparam logic [10:0] Step      = 11'(SPEED);
  localparam logic [10:0] YReach    = 11'(PADDLE_HALF + BALL_HALF);
  localparam logic [10:0] BotLimit  = 11'(SCREEN_H - 1);
  localparam logic [10:0] RightEdge = 11'(SCREEN_W - 1);
  localparam logic [10:0] RFace     = 11'(R_PADDLE_X);
  localparam logic [10:0] LFace     = 11'(L_PADDLE_X + BALL_HALF);
  localparam logic [9:0]  XCentre   = 10'(SCREEN_W / 2);
  localparam logic [9:0]  YCentre   = 10'(SCREEN_H / 2);
  localparam logic [9:0]  Speed10   = 10'(SPEED);
  localparam logic [9:0]  YBot      = 10'(SCREEN_H - 1 - BALL_HALF);
  localparam logic [9:0]  YTop      = 10'(BALL_HALF);
  localparam logic [9:0]  XRHit     = 10'(R_PADDLE_X - BALL_HALF);
  localparam logic [9:0]  XLHit     = 10'(L_PADDLE_X + BALL_HALF);
  localparam logic [7:0]  ServeLast = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]  WinScore  = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       hit_q, hit_d;

  logic        tick;
  logic [10:0] xe, ye, rpe, lpe;
  logic        y_bot, y_top, r_hit, l_hit, r_miss, l_miss;

  assign tick = (x_count == 10'd0) && (y_count == 10'(SCREEN_H));
  assign xe   = {1'b0, x_q};
  assign ye   = {1'b0, y_q};
  assign rpe  = {1'b0, right_paddle_pos};
  assign lpe  = {1'b0, left_paddle_pos};

  // All comparisons kept additive so small paddle positions cannot wrap.
  assign y_bot  = dir_y_q && (ye + Half + Step >= BotLimit);
  assign y_top  = !dir_y_q && (ye <= Half + Step);
  assign r_hit  = dir_x_q && (xe + Half < RFace) && (xe + Half + Step >= RFace) &&
                  (ye + YReach >= rpe) && (ye <= rpe + YReach);
  assign l_hit  = !dir_x_q && (xe > LFace) && (xe <= LFace + Step) &&
                  (ye + YReach >= lpe) && (ye <= lpe + YReach);
  assign r_miss = dir_x_q && (xe + Half + Step >= RightEdge);
  assign l_miss = !dir_x_q && (xe <= Half + Step);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    serve_cnt_d = serve_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    hit_d       = 1'b0;
    if (tick) begin
      unique case (state_q)
        StServe: begin
          if (serve_cnt_q == ServeLast) begin
            state_d     = StPlay;
            serve_cnt_d = 8'd0;
          end else begin
            serve_cnt_d = serve_cnt_q + 8'd1;
          end
        end
        StPlay: begin
          if (r_miss || l_miss) begin
            x_d     = XCentre;
            y_d     = YCentre;
            dir_y_d = 1'b1;
            // Serve toward the player who just lost the point.
            dir_x_d = r_miss;
            if (r_miss) score_l_d = score_l_q + 4'd1;
            else        score_r_d = score_r_q + 4'd1;
            state_d = ((score_l_d == WinScore) || (score_r_d == WinScore)) ? StGameOver
                                                                           : StServe;
          end else begin
            if (y_bot) begin
              y_d     = YBot;
              dir_y_d = 1'b0;
            end else if (y_top) begin
              y_d     = YTop;
              dir_y_d = 1'b1;
            end else begin
              y_d = dir_y_q ? y_q + Speed10 : y_q - Speed10;
            end
            if (r_hit) begin
              x_d     = XRHit;
              dir_x_d = 1'b0;
              hit_d   = 1'b1;
            end else if (l_hit) begin
              x_d     = XLHit;
              dir_x_d = 1'b1;
              hit_d   = 1'b1;
            end else begin
              x_d = dir_x_q ? x_q + Speed10 : x_q - Speed10;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StServe;
      x_q         <= XCentre;
      y_q         <= YCentre;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      serve_cnt_q <= 8'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      serve_cnt_q <= serve_cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      hit_q       <= hit_d;
    end
  end

  assign ball_x_pos  = x_q;
  assign ball_y_pos  = y_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign serving     = (state_q == StServe);
  assign game_over   = (state_q == StGameOver);
  assign hit         = hit_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: a default instance plays scripted rallies, a second
// instance (short serve, low win score, moved right paddle) covers corner bounce and game over.
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       reset, reset_g;
  logic [9:0] x_count, y_count, rp, lp;
  logic [9:0] bx, by, bx_g, by_g;
  logic [3:0] sl, sr, sl_g, sr_g;
  logic       srv, go, hit, srv_g, go_g, hit_g;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ball_engine dut (
    .clk(clk), .reset(reset), .x_count(x_count), .y_count(y_count),
    .right_paddle_pos(rp), .left_paddle_pos(lp),
    .ball_x_pos(bx), .ball_y_pos(by), .score_left(sl), .score_right(sr),
    .serving(srv), .game_over(go), .hit(hit)
  );

  ball_engine #(.R_PADDLE_X(558), .SERVE_FRAMES(2), .WIN_SCORE(3)) dut_g (
    .clk(clk), .reset(reset_g), .x_count(x_count), .y_count(y_count),
    .right_paddle_pos(rp), .left_paddle_pos(lp),
    .ball_x_pos(bx_g), .ball_y_pos(by_g), .score_left(sl_g), .score_right(sr_g),
    .serving(srv_g), .game_over(go_g), .hit(hit_g)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    x_count = 10'd0;
    y_count = 10'd480;
    @(negedge clk);
    x_count = 10'd5;
    y_count = 10'd0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check_eq({tag, "_x"}, int'(bx), ex);
    check_eq({tag, "_y"}, int'(by), ey);
  endtask

  task automatic check_pos_g(input string tag, input int ex, input int ey);
    check_eq({tag, "_x"}, int'(bx_g), ex);
    check_eq({tag, "_y"}, int'(by_g), ey);
  endtask

  initial begin
    reset = 1'b1; reset_g = 1'b1;
    x_count = 10'd5; y_count = 10'd0;
    rp = 10'd100; lp = 10'd300;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_pos("rst", 320, 240);
    check_eq("rst_serving", int'(srv), 1);
    check_eq("rst_game_over", int'(go), 0);
    check_eq("rst_scores", int'({sl, sr}), 0);
    check_eq("rst_hit", int'(hit), 0);

    // Serve hold, then first rally: right paddle far away, bottom wall, right miss.
    tick_n(59);
    check_pos("serve59", 320, 240);
    check_eq("serve59_serving", int'(srv), 1);
    do_tick();
    check_eq("serve60_serving", int'(srv), 0);
    check_pos("serve60", 320, 240);
    do_tick();
    check_pos("play1", 322, 242);
    tick_n(107);
    check_pos("r1_108", 536, 456);
    check_eq("r1_nohit", int'(hit), 0);
    tick_n(8);
    check_pos("r1_116", 552, 472);
    do_tick();
    check_pos("r1_botwall", 554, 474);
    do_tick();
    check_pos("r1_118", 556, 472);
    tick_n(38);
    check_pos("r1_156", 632, 396);
    do_tick();
    check_pos("r1_miss", 320, 240);
    check_eq("r1_score_left", int'(sl), 1);
    check_eq("r1_serving", int'(srv), 1);

    // Second rally: right hit, left hit, top wall, right paddle just out of reach, miss at 633.
    rp = 10'd454; lp = 10'd64;
    tick_n(60);
    tick_n(107);
    check_pos("r2_107", 534, 454);
    do_tick();
    check_pos("r2_rhit", 535, 456);
    check_eq("r2_rhit_pulse", int'(hit), 1);
    @(negedge clk);
    check_eq("r2_rhit_end", int'(hit), 0);
    do_tick();
    check_pos("r2_109", 533, 458);
    tick_n(7);
    check_pos("r2_116", 519, 472);
    do_tick();
    check_pos("r2_117", 517, 474);
    tick_n(205);
    check_pos("r2_322", 107, 64);
    do_tick();
    check_pos("r2_lhit", 105, 62);
    check_eq("r2_lhit_pulse", int'(hit), 1);
    tick_n(28);
    check_pos("r2_351", 161, 6);
    do_tick();
    check_pos("r2_topwall", 163, 5);
    do_tick();
    check_pos("r2_353", 165, 7);
    rp = 10'd401;
    tick_n(184);
    check_pos("r2_537", 533, 375);
    do_tick();
    check_pos("r2_nohit", 535, 377);
    check_eq("r2_nohit_pulse", int'(hit), 0);
    tick_n(48);
    check_pos("r2_586", 631, 473);
    do_tick();
    check_pos("r2_botwall", 633, 474);
    do_tick();
    check_pos("r2_miss", 320, 240);
    check_eq("r2_score_left", int'(sl), 2);

    // Third rally: left paddle out of reach, left miss scores for the right player.
    rp = 10'd454; lp = 10'd300;
    tick_n(60);
    tick_n(108);
    check_pos("r3_rhit", 535, 456);
    tick_n(214);
    check_pos("r3_322", 107, 64);
    do_tick();
    check_pos("r3_nohit", 105, 62);
    check_eq("r3_nohit_pulse", int'(hit), 0);
    tick_n(27);
    check_pos("r3_350", 51, 8);
    tick_n(2);
    check_pos("r3_topwall", 47, 5);
    tick_n(20);
    check_pos("r3_372", 7, 45);
    do_tick();
    check_pos("r3_miss", 320, 240);
    check_eq("r3_score_right", int'(sr), 1);
    check_eq("r3_score_left", int'(sl), 2);
    check_eq("r3_serving", int'(srv), 1);
    tick_n(61);
    check_pos("r3_serve_left", 318, 242);
    do_tick();
    check_pos("r3_play2", 316, 244);

    // Reset coinciding with tick mid-play.
    @(negedge clk);
    reset = 1'b1; x_count = 10'd0; y_count = 10'd480;
    @(negedge clk);
    reset = 1'b0; x_count = 10'd5; y_count = 10'd0;
    check_pos("rst_tick", 320, 240);
    check_eq("rst_tick_scores", int'({sl, sr}), 0);
    check_eq("rst_tick_serving", int'(srv), 1);

    // Second instance: bottom wall and right paddle on the same tick.
    rp = 10'd472;
    @(negedge clk);
    reset_g = 1'b0;
    tick_n(2);
    check_eq("g_serve_done", int'(srv_g), 0);
    tick_n(116);
    check_pos_g("g_116", 552, 472);
    do_tick();
    check_pos_g("g_corner", 553, 474);
    check_eq("g_corner_hit", int'(hit_g), 1);
    @(negedge clk);
    check_eq("g_corner_hit_end", int'(hit_g), 0);
    do_tick();
    check_pos_g("g_corner_next", 551, 472);

    // Three right misses reach the winning score and freeze the game.
    reset_g = 1'b1;
    @(negedge clk);
    reset_g = 1'b0;
    rp = 10'd100;
    for (int p = 0; p < 3; p++) begin
      tick_n(159);
      check_eq("g_score_left", int'(sl_g), p + 1);
      check_eq("g_serving", int'(srv_g), (p < 2) ? 1 : 0);
    end
    check_eq("g_game_over", int'(go_g), 1);
    tick_n(5);
    check_pos_g("g_frozen", 320, 240);
    check_eq("g_frozen_score", int'(sl_g), 3);
    check_eq("g_frozen_go", int'(go_g), 1);
    reset_g = 1'b1;
    @(negedge clk);
    reset_g = 1'b0;
    check_eq("g_rst_score", int'({sl_g, sr_g}), 0);
    check_eq("g_rst_go", int'(go_g), 0);
    check_eq("g_rst_serving", int'(srv_g), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
